// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MIPS32 EX/MEM stage and a req/ack data memory port.
// Optional ack timeout with bus_err reporting is built when LSU_TIMEOUT_EN is defined.
module lsu_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        store,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

   state_t      state;
   logic        misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic        l_store;
   logic [2:0]  l_op;
   logic [1:0]  l_lane;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
      $error("lsu_ctrl: TIMEOUT must be within 2..255");
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      misaligned = 1'b0;
      st_be      = 4'b1111;
      st_wdata   = wdata;
      case (op[1:0])
         2'b00: begin
            st_be    = 4'b1000 >> addr[1:0];
            st_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            misaligned = addr[0];
            st_be      = addr[1] ? 4'b0011 : 4'b1100;
            st_wdata   = {2{wdata[15:0]}};
         end
         2'b10:   misaligned = |addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   assign stall = (state == ACCESS) || (state == IDLE && start && !misaligned);

   // Big-endian lane select: lane 0 is the most significant byte of the word.
   function automatic logic [31:0] load_value(input logic [31:0] word,
                                              input logic [2:0]  lop,
                                              input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      h = lane[1] ? word[15:0] : word[31:16];
      case (lop[1:0])
         2'b00:   r = {{24{b[7] & ~lop[2]}}, b};
         2'b01:   r = {{16{h[15] & ~lop[2]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] tmo_cnt;
`else
   assign bus_err = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         done      <= 1'b0;
         addr_err  <= 1'b0;
         rdata     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         l_store   <= 1'b0;
         l_op      <= '0;
         l_lane    <= '0;
`ifdef LSU_TIMEOUT_EN
         bus_err   <= 1'b0;
         tmo_cnt   <= '0;
`endif
      end else begin
         done     <= 1'b0;
         addr_err <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         bus_err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  if (misaligned) begin
                     state    <= ERR;
                     addr_err <= 1'b1;
                  end else begin
                     state     <= ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= store;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_be    <= store ? st_be : 4'b1111;
                     mem_wdata <= store ? st_wdata : '0;
                     l_store   <= store;
                     l_op      <= op;
                     l_lane    <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
                     tmo_cnt   <= '0;
`endif
                  end
               end
            end
            ACCESS: begin
               // An ack on the limit cycle still completes normally.
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  done    <= 1'b1;
                  if (!l_store) rdata <= load_value(mem_rdata, l_op, l_lane);
               end
`ifdef LSU_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  bus_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed test-plan cases, reset abort, then randomized
// transactions compared every cycle against a transaction-level model.
module tb_lsu_ctrl;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        store = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        stall, done, addr_err, bus_err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_lat = -1;
   logic checking = 1'b0;

   logic        exp_stall = 0, exp_done = 0, exp_aerr = 0, exp_berr = 0, exp_req = 0, exp_we = 0;
   logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
   logic [3:0]  exp_be = '0;
   logic        obs_we = 0;
   logic [31:0] obs_addr = '0, obs_wdata = '0;
   logic [3:0]  obs_be = '0;

   lsu_ctrl #(.TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .start(start), .store(store), .op(op),
      .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
      .addr_err(addr_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   function automatic int nbytes(input logic [2:0] o);
      return 1 << o[1:0];
   endfunction

   function automatic logic model_mis(input logic [2:0] o, input logic [31:0] a);
      if (o[1:0] == 2'b11) return 1'b1;
      return (int'(a[1:0]) % nbytes(o)) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] o,
                                              input logic [31:0] a);
      int nb = nbytes(o);
      int sh = 8 * (4 - nb - int'(a[1:0]));
      logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
      logic [63:0] f = ({32'd0, word} >> sh) & mask;
      if (!o[2] && f[8*nb-1]) f = f | ~mask;
      return f[31:0];
   endfunction

   function automatic logic [3:0] model_be(input logic st, input logic [2:0] o, input logic [31:0] a);
      int nb = nbytes(o);
      int v;
      if (!st) return 4'hF;
      v = ((1 << nb) - 1) << (4 - nb - int'(a[1:0]));
      return 4'(v);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] o, input logic [31:0] wd);
      int nb = nbytes(o);
      logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
      logic [63:0] w = {32'd0, wd} & mask;
      logic [63:0] v = '0;
      for (int i = 0; i < 4 / nb; i++) v = v | (w << (8 * nb * i));
      return v[31:0];
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (checking) begin
         check("stall", 32'(stall), 32'(exp_stall));
         check("done", 32'(done), 32'(exp_done));
         check("addr_err", 32'(addr_err), 32'(exp_aerr));
         check("bus_err", 32'(bus_err), 32'(exp_berr));
         check("mem_req", 32'(mem_req), 32'(exp_req));
         check("rdata", rdata, exp_rdata);
         if (exp_req) begin
            check("mem_we", 32'(mem_we), 32'(exp_we));
            check("mem_addr", mem_addr, exp_addr);
            check("mem_be", 32'(mem_be), 32'(exp_be));
            if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            obs_we    = mem_we;
            obs_addr  = mem_addr;
            obs_be    = mem_be;
            obs_wdata = mem_wdata;
         end
         if (done) done_lat = cyc - start_cyc;
      end
   end

   task automatic set_idle_exp();
      exp_stall = 0; exp_done = 0; exp_aerr = 0; exp_berr = 0; exp_req = 0;
   endtask

   task automatic scramble();
      store = 1'($urandom); op = 3'($urandom); addr = $urandom; wdata = $urandom;
      mem_ack = 1'($urandom); mem_rdata = $urandom;
   endtask

   task automatic idle_cycle();
      @(posedge clock); #1;
      scramble();
      start = 1'b0;
      set_idle_exp();
   endtask

   task automatic settle();
      @(negedge clock); #1;
   endtask

   // One access: start in cycle 0, ack in cycle k, done (or bus_err) in the cycle after.
   task automatic run(input logic st, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] wd, input int k, input logic [31:0] word,
                      input logic poke);
      logic mis = model_mis(o, a);
      logic timed;
      int lim;
`ifdef LSU_TIMEOUT_EN
      timed = (k > TMO);
`else
      timed = 1'b0;
`endif
      lim = timed ? TMO : k;
      @(posedge clock); #1;
      start = 1'b1; store = st; op = o; addr = a; wdata = wd;
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      start_cyc = cyc; done_lat = -1;
      set_idle_exp();
      exp_stall = !mis;
      if (mis) begin
         @(posedge clock); #1;
         scramble();
         start = 1'($urandom);
         set_idle_exp();
         exp_aerr = 1;
         return;
      end
      exp_we = st; exp_addr = {a[31:2], 2'b00}; exp_be = model_be(st, o, a);
      exp_wdata = model_wdata(o, wd);
      for (int c = 1; c <= lim; c++) begin
         @(posedge clock); #1;
         scramble();
         start = 1'($urandom);
         mem_ack = !timed && (c == k);
         mem_rdata = mem_ack ? word : $urandom;
         set_idle_exp();
         exp_req = 1; exp_stall = 1;
      end
      @(posedge clock); #1;
      scramble();
      set_idle_exp();
      if (timed) begin
         start = 1'b0;
         exp_berr = 1;
      end else begin
         start = poke ? 1'b1 : 1'($urandom);
         if (poke) begin store = 0; op = 3'b010; addr = 32'h200; end
         exp_done = 1;
         if (!st) exp_rdata = model_load(word, o, a);
      end
   endtask

   initial begin
      logic [31:0] w;
      w = 32'h80FF7F01;

      // Reset state
      repeat (2) @(negedge clock);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      set_idle_exp();
      checking = 1'b1;
      repeat (2) idle_cycle();

      // Loads of 0x80FF7F01 at 0x100 with immediate ack
      run(0, 3'b000, 32'h100, 0, 1, w, 0); settle();
      check("lb_100", rdata, 32'hFFFFFF80);
      check("lb_latency", done_lat, 2);
      run(0, 3'b100, 32'h100, 0, 1, w, 0); settle();
      check("lbu_100", rdata, 32'h00000080);
      run(0, 3'b000, 32'h102, 0, 1, w, 0); settle();
      check("lb_102", rdata, 32'h0000007F);
      run(0, 3'b001, 32'h100, 0, 1, w, 0); settle();
      check("lh_100", rdata, 32'hFFFF80FF);
      run(0, 3'b101, 32'h100, 0, 1, w, 0); settle();
      check("lhu_100", rdata, 32'h000080FF);
      run(0, 3'b001, 32'h102, 0, 1, w, 0); settle();
      check("lh_102", rdata, 32'h00007F01);
      run(0, 3'b010, 32'h100, 0, 1, w, 0); settle();
      check("lw_100", rdata, 32'h80FF7F01);

      // Stores
      run(1, 3'b000, 32'h103, 32'h123456AB, 1, 0, 0); settle();
      check("sb_addr", obs_addr, 32'h100);
      check("sb_be", 32'(obs_be), 32'h1);
      check("sb_we", 32'(obs_we), 32'd1);
      check("sb_wdata", obs_wdata, 32'hABABABAB);
      run(1, 3'b001, 32'h102, 32'h0000BEEF, 1, 0, 0); settle();
      check("sh_be", 32'(obs_be), 32'h3);
      check("sh_wdata", obs_wdata, 32'hBEEFBEEF);
      check("store_keeps_rdata", rdata, 32'h80FF7F01);

      // Misaligned requests
      run(0, 3'b010, 32'h102, 0, 1, w, 0); settle();
      check("lw_102_rdata", rdata, 32'h80FF7F01);
      check("lw_102_no_done", done_lat, -1);
      run(0, 3'b001, 32'h101, 0, 1, w, 0); settle();
      check("lh_101_rdata", rdata, 32'h80FF7F01);

      // Delayed ack at cycle 6, start poked during DONE
      run(0, 3'b010, 32'h100, 0, 6, 32'h13572468, 1); settle();
      check("slow_latency", done_lat, 7);
      check("slow_rdata", rdata, 32'h13572468);
      repeat (2) idle_cycle();

      // Reset in cycle 3 of a pending load
      @(posedge clock); #1;
      start = 1; store = 0; op = 3'b010; addr = 32'h300; mem_ack = 0;
      start_cyc = cyc; done_lat = -1;
      set_idle_exp(); exp_stall = 1;
      exp_we = 0; exp_addr = 32'h300; exp_be = 4'hF;
      repeat (2) begin
         @(posedge clock); #1;
         start = 0; mem_ack = 0;
         set_idle_exp(); exp_req = 1; exp_stall = 1;
      end
      @(posedge clock); #1;
      checking = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("arst_mem_req", 32'(mem_req), 32'd0);
      check("arst_stall", 32'(stall), 32'd0);
      check("arst_rdata", rdata, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      set_idle_exp(); exp_rdata = '0;
      checking = 1'b1;
      repeat (4) idle_cycle();
      settle();
      check("arst_no_done", done_lat, -1);

`ifdef LSU_TIMEOUT_EN
      run(0, 3'b010, 32'h100, 0, 20, w, 0); settle();
      check("tmo_no_done", done_lat, -1);
      check("tmo_rdata", rdata, 32'd0);
      run(0, 3'b010, 32'h100, 0, 2, w, 0); settle();
      check("after_tmo_lw", rdata, 32'h80FF7F01);
`endif

      // Randomized transactions
      for (int t = 0; t < 300; t++) begin
         logic [2:0] o;
         int k;
         o = 3'($urandom);
         if ($urandom % 4 != 0) o[1:0] = 2'($urandom % 3);
         k = 1 + int'($urandom % 4);
         if ($urandom % 8 == 0) k = 5 + int'($urandom % 4);
         run(1'($urandom), o, $urandom, $urandom, k, $urandom, 0);
         repeat ($urandom % 3) idle_cycle();
      end
      idle_cycle();

      @(posedge clock); #1;
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
